// File: rtl/sh_ubc_gen_if.sv
// rtl/sh_ubc_gen_if.sv - register bus and monitored cycle bundle for the user break controller
interface sh_ubc_gen_if;
   // register bus (IBUS)
   logic [31:0] IBUS_A;
   logic [31:0] IBUS_DI;
   logic [31:0] IBUS_DO;
   logic [3:0]  IBUS_BA;
   logic        IBUS_WE;
   logic        IBUS_REQ;
   logic        IBUS_BUSY;
   logic        IBUS_ACT;
   // monitored internal bus cycle
   logic [31:0] MON_A;
   logic [31:0] MON_D;
   logic [3:0]  MON_BA;
   logic        MON_WE;
   logic        MON_IF;
   logic        MON_DMA;
   logic        MON_REQ;

   modport master (
      output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
      output MON_A, MON_D, MON_BA, MON_WE, MON_IF, MON_DMA, MON_REQ,
      input  IBUS_DO, IBUS_BUSY, IBUS_ACT
   );

   modport slave (
      input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
      input  MON_A, MON_D, MON_BA, MON_WE, MON_IF, MON_DMA, MON_REQ,
      output IBUS_DO, IBUS_BUSY, IBUS_ACT
   );
endinterface

// File: rtl/sh_ubc_gen.sv
// rtl/sh_ubc_gen.sv - parametrised user break controller with live bus cycle matching
module sh_ubc_gen #(
   parameter int          NCH     = 2,
   parameter logic [3:0]  DATA_EN = 4'b0010,
   parameter logic [31:0] BASE    = 32'hFFFFFF40
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           CE_R,
   input  logic           CE_F,
   sh_ubc_gen_if.slave    bus,
   output logic [NCH-1:0] MATCH,
   output logic           IRQ
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [31:0]    r_bar  [NCH];
   logic [31:0]    r_bamr [NCH];
   logic [31:0]    r_bdr  [NCH];
   logic [31:0]    r_bdmr [NCH];
   logic [7:0]     r_bbr  [NCH];
   logic           r_seq;
   logic [NCH-1:0] r_cmf;
   logic [NCH-1:0] r_arm;
   logic [31:0]    r_reg_do;

   logic           w_in_win;
   logic [31:0]    w_off;
   logic [CHW-1:0] w_ch;
   logic [4:0]     w_reg;
   logic           w_ch_ok;
   logic           w_wr;
   logic           w_hi_en;
   logic           w_lo_en;
   logic [15:0]    w_h16;
   logic           w_brcr_wr;
   logic [15:0]    w_brcr;
   logic [31:0]    w_rd;
   logic [31:0]    w_lane;
   logic [2:0]     w_pop;
   logic           w_seq;
   logic [NCH-1:0] w_hit;
   logic [NCH-1:0] w_qual;
   logic           w_irq;
   logic           w_unused;

   // 33-bit window bounds so a window touching the top of the address space cannot wrap
   assign w_in_win = ({1'b0, bus.IBUS_A} >= {1'b0, BASE}) &&
                     ({1'b0, bus.IBUS_A} <  ({1'b0, BASE} + 33'(32 * NCH)));
   assign w_off    = bus.IBUS_A - BASE;
   assign w_ch     = w_off[CHW+4:5];
   assign w_reg    = w_off[4:0];
   assign w_ch_ok  = (int'(w_ch) < NCH);

   assign w_wr      = CE_R && w_in_win && bus.IBUS_REQ && bus.IBUS_WE;
   assign w_hi_en   = |bus.IBUS_BA[3:2];
   assign w_lo_en   = |bus.IBUS_BA[1:0];
   // 16-bit registers take whichever half the master enabled, upper half preferred
   assign w_h16     = w_hi_en ? bus.IBUS_DI[31:16] : bus.IBUS_DI[15:0];
   assign w_brcr_wr = w_wr && (w_ch == '0) && (w_reg == 5'h18) && (w_hi_en || w_lo_en);
   assign w_unused  = &{1'b0, w_off[31:CHW+5], w_h16};

   assign bus.IBUS_BUSY = 1'b0;
   assign bus.IBUS_ACT  = w_in_win;
   assign bus.IBUS_DO   = w_in_win ? r_reg_do : 32'h0;

   // monitored cycle decode and per-channel comparators
   always_comb begin
      w_lane = {{8{bus.MON_BA[3]}}, {8{bus.MON_BA[2]}}, {8{bus.MON_BA[1]}}, {8{bus.MON_BA[0]}}};
      w_pop  = 3'(bus.MON_BA[0]) + 3'(bus.MON_BA[1]) + 3'(bus.MON_BA[2]) + 3'(bus.MON_BA[3]);
      w_seq  = r_seq && (NCH >= 2);
      w_hit  = '0;
      w_qual = '0;
      for (int i = 0; i < NCH; i++) begin
         logic a_ok, c_ok, s_ok, d_ok;
         a_ok = (((bus.MON_A ^ r_bar[i]) & ~r_bamr[i]) == 32'h0);
         c_ok = (bus.MON_DMA ? r_bbr[i][7] : r_bbr[i][6]) &&
                (bus.MON_IF  ? r_bbr[i][4] : r_bbr[i][5]) &&
                (bus.MON_WE  ? r_bbr[i][3] : r_bbr[i][2]);
         case (r_bbr[i][1:0])
            2'b00:   s_ok = 1'b1;
            2'b01:   s_ok = (w_pop == 3'd1);
            2'b10:   s_ok = (w_pop == 3'd2);
            default: s_ok = (w_pop == 3'd4);
         endcase
         // instruction fetches never take part in the data compare
         d_ok = !DATA_EN[i] || bus.MON_IF ||
                (((bus.MON_D ^ r_bdr[i]) & ~r_bdmr[i] & w_lane) == 32'h0);
         w_hit[i] = a_ok && c_ok && s_ok && d_ok;
      end
      w_qual[0] = w_hit[0] && bus.MON_REQ;
      for (int i = 1; i < NCH; i++) begin
         w_qual[i] = w_hit[i] && bus.MON_REQ && (!w_seq || r_arm[i-1]);
      end
      w_irq = w_seq ? w_qual[NCH-1] : |w_qual;
   end

   // register read mux; 16-bit registers appear on both halves
   always_comb begin
      w_brcr           = 16'h0;
      w_brcr[3]        = r_seq;
      w_brcr[8+:NCH]   = r_cmf;
      w_rd             = 32'h0;
      if (w_ch_ok) begin
         case (w_reg)
            5'h00:   w_rd = r_bar[w_ch];
            5'h04:   w_rd = r_bamr[w_ch];
            5'h08:   w_rd = {8'h0, r_bbr[w_ch], 8'h0, r_bbr[w_ch]};
            5'h10:   w_rd = r_bdr[w_ch];
            5'h14:   w_rd = r_bdmr[w_ch];
            5'h18:   w_rd = (w_ch == '0) ? {w_brcr, w_brcr} : 32'h0;
            default: w_rd = 32'h0;
         endcase
      end
   end

   // register writes, flag/arm update and registered break outputs on CE_R
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++) begin
            r_bar[i]  <= 32'h0;
            r_bamr[i] <= 32'h0;
            r_bdr[i]  <= 32'h0;
            r_bdmr[i] <= 32'h0;
            r_bbr[i]  <= 8'h0;
         end
         r_seq <= 1'b0;
         r_cmf <= '0;
         r_arm <= '0;
         MATCH <= '0;
         IRQ   <= 1'b0;
      end else if (CE_R) begin
         MATCH <= w_qual;
         IRQ   <= w_irq;
         // a new hit wins over a write-0 clear on the same edge
         r_cmf <= (w_brcr_wr ? (r_cmf & w_h16[8+:NCH]) : r_cmf) | w_qual;
         r_arm <= w_brcr_wr ? '0 : (r_arm | w_qual);
         if (w_brcr_wr) r_seq <= w_h16[3];
         for (int i = 0; i < NCH; i++) begin
            if (w_wr && (w_ch == CHW'(i))) begin
               case (w_reg)
                  5'h00: begin
                     if (w_hi_en) r_bar[i][31:16] <= bus.IBUS_DI[31:16];
                     if (w_lo_en) r_bar[i][15:0]  <= bus.IBUS_DI[15:0];
                  end
                  5'h04: begin
                     if (w_hi_en) r_bamr[i][31:16] <= bus.IBUS_DI[31:16];
                     if (w_lo_en) r_bamr[i][15:0]  <= bus.IBUS_DI[15:0];
                  end
                  5'h08: if (w_hi_en || w_lo_en) r_bbr[i] <= w_h16[7:0];
                  5'h10: if (DATA_EN[i]) begin
                     if (w_hi_en) r_bdr[i][31:16] <= bus.IBUS_DI[31:16];
                     if (w_lo_en) r_bdr[i][15:0]  <= bus.IBUS_DI[15:0];
                  end
                  5'h14: if (DATA_EN[i]) begin
                     if (w_hi_en) r_bdmr[i][31:16] <= bus.IBUS_DI[31:16];
                     if (w_lo_en) r_bdmr[i][15:0]  <= bus.IBUS_DI[15:0];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // read data captured on the falling-phase enable
   always_ff @(posedge CLK) begin
      if (RST) r_reg_do <= 32'h0;
      else if (CE_F && w_in_win && bus.IBUS_REQ && !bus.IBUS_WE) r_reg_do <= w_rd;
   end
endmodule

// File: tb/tb_sh_ubc_gen.sv
// tb/tb_sh_ubc_gen.sv - directed self-checking bench for sh_ubc_gen
module tb_sh_ubc_gen;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CE_R = 1'b1;
   logic       CE_F = 1'b1;
   logic [1:0] MATCH2;
   logic       IRQ2;
   logic [3:0] MATCH4;
   logic       IRQ4;
   int         n_chk = 0;
   int         n_err = 0;
   logic [31:0] d2, d4;
   logic        a2, a4;

   localparam logic [31:0] A_BAR0  = 32'hFFFFFF40;
   localparam logic [31:0] A_BAMR0 = 32'hFFFFFF44;
   localparam logic [31:0] A_BBR0  = 32'hFFFFFF48;
   localparam logic [31:0] A_BDR0  = 32'hFFFFFF50;
   localparam logic [31:0] A_BRCR  = 32'hFFFFFF58;
   localparam logic [31:0] A_BAR1  = 32'hFFFFFF60;
   localparam logic [31:0] A_BBR1  = 32'hFFFFFF68;
   localparam logic [31:0] A_BDR1  = 32'hFFFFFF70;
   localparam logic [31:0] A_BDMR1 = 32'hFFFFFF74;
   localparam logic [31:0] A_BAR3  = 32'hFFFFFFA0;
   localparam logic [31:0] A_BDR3  = 32'hFFFFFFB0;

   sh_ubc_gen_if if2 ();
   sh_ubc_gen_if if4 ();

   assign if4.IBUS_A   = if2.IBUS_A;
   assign if4.IBUS_DI  = if2.IBUS_DI;
   assign if4.IBUS_BA  = if2.IBUS_BA;
   assign if4.IBUS_WE  = if2.IBUS_WE;
   assign if4.IBUS_REQ = if2.IBUS_REQ;
   assign if4.MON_A    = if2.MON_A;
   assign if4.MON_D    = if2.MON_D;
   assign if4.MON_BA   = if2.MON_BA;
   assign if4.MON_WE   = if2.MON_WE;
   assign if4.MON_IF   = if2.MON_IF;
   assign if4.MON_DMA  = if2.MON_DMA;
   assign if4.MON_REQ  = if2.MON_REQ;

   sh_ubc_gen u_dut2 (
      .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
      .bus(if2.slave), .MATCH(MATCH2), .IRQ(IRQ2)
   );

   sh_ubc_gen #(.NCH(4), .DATA_EN(4'b1000), .BASE(32'hFFFFFF40)) u_dut4 (
      .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
      .bus(if4.slave), .MATCH(MATCH4), .IRQ(IRQ4)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      if2.IBUS_A   = 32'h0;
      if2.IBUS_DI  = 32'h0;
      if2.IBUS_BA  = 4'h0;
      if2.IBUS_WE  = 1'b0;
      if2.IBUS_REQ = 1'b0;
      if2.MON_A    = 32'h0;
      if2.MON_D    = 32'h0;
      if2.MON_BA   = 4'h0;
      if2.MON_WE   = 1'b0;
      if2.MON_IF   = 1'b0;
      if2.MON_DMA  = 1'b0;
      if2.MON_REQ  = 1'b0;
   endtask

   task automatic cyc(input bit do_wr, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] wba, input bit do_mon, input logic [31:0] ma,
                      input logic [31:0] md, input logic [3:0] mba,
                      input bit mwe, input bit mif, input bit mdma);
      @(negedge CLK);
      if2.IBUS_A   = wa;
      if2.IBUS_DI  = wd;
      if2.IBUS_BA  = wba;
      if2.IBUS_WE  = do_wr;
      if2.IBUS_REQ = do_wr;
      if2.MON_A    = ma;
      if2.MON_D    = md;
      if2.MON_BA   = mba;
      if2.MON_WE   = mwe;
      if2.MON_IF   = mif;
      if2.MON_DMA  = mdma;
      if2.MON_REQ  = do_mon;
      @(posedge CLK);
      #1;
      drive_idle();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
      cyc(1'b1, a, d, ba, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mon(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba,
                      input bit we, input bit ifch, input bit dma);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, d, ba, we, ifch, dma);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] o2, output logic [31:0] o4);
      @(negedge CLK);
      if2.IBUS_A   = a;
      if2.IBUS_BA  = 4'hF;
      if2.IBUS_WE  = 1'b0;
      if2.IBUS_REQ = 1'b1;
      @(posedge CLK);
      #1;
      o2 = if2.IBUS_DO;
      o4 = if4.IBUS_DO;
      drive_idle();
   endtask

   task automatic idle();
      @(negedge CLK);
      drive_idle();
      @(posedge CLK);
      #1;
   endtask

   task automatic act(input logic [31:0] a, output logic o2, output logic o4);
      @(negedge CLK);
      if2.IBUS_A = a;
      #1;
      o2 = if2.IBUS_ACT;
      o4 = if4.IBUS_ACT;
      drive_idle();
   endtask

   initial begin
      drive_idle();
      // reset state
      repeat (3) @(posedge CLK);
      #1;
      check("rst_match", 32'(MATCH2), 32'h0);
      check("rst_irq", 32'(IRQ2), 32'h0);
      check("busy", 32'(if2.IBUS_BUSY), 32'h0);
      rd(A_BBR0, d2, d4);
      check("rst_rd_in_reset", d2, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      rd(A_BAR0, d2, d4);
      check("rst_bar0", d2, 32'h0);
      rd(A_BRCR, d2, d4);
      check("rst_brcr", d2, 32'h0);
      mon(32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      check("bbr0_disabled", 32'(MATCH2), 32'h0);

      // address/mask on channel 0
      wr(A_BAR0, 32'h06001000, 4'hF);
      wr(A_BAMR0, 32'h0000000F, 4'hF);
      wr(A_BBR0, 32'h00540000, 4'b1100);
      rd(A_BBR0, d2, d4);
      check("bbr0_mirror", d2, 32'h00540054);
      mon(32'h0600100C, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      check("addr_hit_match", 32'(MATCH2), 32'h1);
      check("addr_hit_irq", 32'(IRQ2), 32'h1);
      idle();
      check("irq_pulse_end", 32'(IRQ2), 32'h0);
      check("match_pulse_end", 32'(MATCH2), 32'h0);
      rd(A_BRCR, d2, d4);
      check("cmf0_set", d2, 32'h01000100);
      mon(32'h06001010, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      check("addr_miss", 32'(MATCH2), 32'h0);

      // data compare on channel 1
      wr(A_BAR1, 32'h06002000, 4'hF);
      wr(A_BBR1, 32'h000000EA, 4'b0011);
      wr(A_BDR1, 32'h00001234, 4'hF);
      wr(A_BDMR1, 32'h00000000, 4'hF);
      rd(A_BDR1, d2, d4);
      check("bdr1_rd", d2, 32'h00001234);
      mon(32'h06002000, 32'h00001234, 4'b0011, 1'b1, 1'b0, 1'b0);
      check("data_hit", 32'(MATCH2), 32'h2);
      check("data_hit_irq", 32'(IRQ2), 32'h1);
      mon(32'h06002000, 32'h00001235, 4'b0011, 1'b1, 1'b0, 1'b0);
      check("data_miss", 32'(MATCH2), 32'h0);
      mon(32'h06002000, 32'h00001234, 4'hF, 1'b1, 1'b0, 1'b0);
      check("size_miss", 32'(MATCH2), 32'h0);
      mon(32'h06002000, 32'hABCD1234, 4'b0011, 1'b1, 1'b0, 1'b1);
      check("lane_mask_dma_hit", 32'(MATCH2), 32'h2);
      rd(A_BRCR, d2, d4);
      check("cmf01_set", d2, 32'h03000300);
      wr(A_BDR0, 32'hDEADBEEF, 4'hF);
      rd(A_BDR0, d2, d4);
      check("bdr0_absent", d2, 32'h0);
      check("bdr0_absent_n4", d4, 32'h0);
      wr(A_BRCR, 32'h00000000, 4'b1100);
      rd(A_BRCR, d2, d4);
      check("cmf_clear", d2, 32'h0);

      // sequential mode
      wr(A_BRCR, 32'h00080008, 4'b1100);
      rd(A_BRCR, d2, d4);
      check("seq_set", d2, 32'h00080008);
      mon(32'h06002000, 32'h00001234, 4'b0011, 1'b1, 1'b0, 1'b0);
      check("seq_b_first_match", 32'(MATCH2), 32'h0);
      check("seq_b_first_irq", 32'(IRQ2), 32'h0);
      rd(A_BRCR, d2, d4);
      check("seq_b_first_cmf", d2, 32'h00080008);
      mon(32'h0600100C, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      check("seq_a_match", 32'(MATCH2), 32'h1);
      check("seq_a_irq", 32'(IRQ2), 32'h0);
      mon(32'h06002000, 32'h00001234, 4'b0011, 1'b1, 1'b0, 1'b0);
      check("seq_b_match", 32'(MATCH2), 32'h2);
      check("seq_b_irq", 32'(IRQ2), 32'h1);
      rd(A_BRCR, d2, d4);
      check("seq_cmf", d2, 32'h03080308);
      // same-cycle hit on both channels from idle must not chain
      wr(A_BAR0, 32'h06002000, 4'hF);
      wr(A_BAMR0, 32'h00000000, 4'hF);
      wr(A_BBR0, 32'h000000FC, 4'b0011);
      wr(A_BRCR, 32'h00080008, 4'b1100);
      mon(32'h06002000, 32'h00001234, 4'b0011, 1'b1, 1'b0, 1'b0);
      check("seq_same_match", 32'(MATCH2), 32'h1);
      check("seq_same_irq", 32'(IRQ2), 32'h0);
      rd(A_BRCR, d2, d4);
      check("seq_same_cmf", d2, 32'h01080108);

      // flag clear racing a new hit: the hit wins
      cyc(1'b1, A_BRCR, 32'h00080008, 4'b1100, 1'b1, 32'h06002000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      check("race_match", 32'(MATCH2), 32'h1);
      rd(A_BRCR, d2, d4);
      check("race_cmf0_kept", d2, 32'h01080108);
      wr(A_BRCR, 32'h00080008, 4'b1100);
      rd(A_BRCR, d2, d4);
      check("clear_no_race", d2, 32'h00080008);

      // four-channel variant
      wr(A_BAR3, 32'h12345678, 4'hF);
      rd(A_BAR3, d2, d4);
      check("n4_bar3", d4, 32'h12345678);
      check("n2_outside", d2, 32'h0);
      wr(A_BDR3, 32'hCAFEF00D, 4'hF);
      rd(A_BDR3, d2, d4);
      check("n4_bdr3", d4, 32'hCAFEF00D);
      act(32'hFFFFFFC0, a2, a4);
      check("n4_act_past_end", 32'(a4), 32'h0);
      act(32'hFFFFFFBC, a2, a4);
      check("n4_act_last", 32'(a4), 32'h1);
      act(32'hFFFFFF80, a2, a4);
      check("n2_act_past_end", 32'(a2), 32'h0);
      act(32'hFFFFFF3C, a2, a4);
      check("n2_act_below", 32'(a2), 32'h0);

      // reset mid-operation discards flags
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h06002000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_match", 32'(MATCH2), 32'h0);
      check("midrst_irq", 32'(IRQ2), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      rd(A_BRCR, d2, d4);
      check("midrst_brcr", d2, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
